// File: rtl/pool_pkg.sv
// Shared types and default geometry for the 2x2/stride-2 max-pooling stage.
package pool_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_IN_W   = 6;
  localparam int DEF_IN_H   = 6;

  localparam int OUT_W = DEF_IN_W / 2;
  localparam int OUT_H = DEF_IN_H / 2;
  localparam int OUT_N = OUT_W * OUT_H;

  typedef logic signed [DEF_DATA_W-1:0] data_t;
  typedef logic [1:0] phase_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Window/phase walker: issues the four reads of each 2x2 window in row-major
// window order and flags when the final read of the frame has been issued.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int IN_H   = DEF_IN_H,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output phase_t            phase,
  output logic              last
);

  localparam int OW = IN_W / 2;
  localparam int OH = IN_H / 2;
  localparam int CW = $clog2((OW > OH) ? OW : OH) + 1;

  logic [CW-1:0]     wr;
  logic [CW-1:0]     wc;
  phase_t            p;
  logic              row_end;
  logic              final_rd;
  logic [ADDR_W-1:0] addr_c;

  always_comb begin
    row_end  = (wc == CW'(OW - 1));
    final_rd = (p == 2'd3) && row_end && (wr == CW'(OH - 1));
    addr_c   = ADDR_W'(2 * IN_W * int'(wr) + 2 * int'(wc)
                       + (p[1] ? IN_W : 0) + (p[0] ? 1 : 0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      phase   <= '0;
      last    <= 1'b0;
      wr      <= '0;
      wc      <= '0;
      p       <= '0;
    end else if (clr) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      phase   <= '0;
      last    <= 1'b0;
      wr      <= '0;
      wc      <= '0;
      p       <= '0;
    end else if (en && !last) begin
      rd_en   <= 1'b1;
      rd_addr <= addr_c;
      phase   <= p;
      p       <= p + 2'd1;
      if (p == 2'd3) begin
        if (final_rd) begin
          last <= 1'b1;
        end else if (row_end) begin
          wc <= '0;
          wr <= wr + 1'b1;
        end else begin
          wc <= wc + 1'b1;
        end
      end
    end else begin
      rd_en <= 1'b0;
    end
  end

endmodule

// File: rtl/pool_2b2.sv
// 2x2 stride-2 max-pooling stage reading a conv feature map from a sync buffer.
// Optional POOL_RELU_EN clamps negative pooled results to zero.
module pool_2b2
  import pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IN_W   = DEF_IN_W,
  parameter int IN_H   = DEF_IN_H,
  parameter int ADDR_W = 6,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_n,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy,
  output logic              done
);

  state_t                   state;
  state_t                   state_nx;
  phase_t                   phase;
  logic                     last;
  logic                     tag_vld;
  phase_t                   tag_p;
  logic signed [DATA_W-1:0] mx;
  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W-1:0] cand;
  logic signed [DATA_W-1:0] res;
  logic [IDX_W-1:0]         cnt;

  pool_addr_gen #(
    .IN_W   (IN_W),
    .IN_H   (IN_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (run_n),
    .en      (state == READ),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .phase   (phase),
    .last    (last)
  );

  always_comb begin
    state_nx = state;
    if (run_n) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = READ;
        READ:    if (last) state_nx = DRAIN;
        DRAIN:   state_nx = DONE;
        default: state_nx = DONE;
      endcase
    end
  end

  // Tag 0 starts a new window; later tags only raise the running max.
  always_comb begin
    din  = $signed(rd_data);
    cand = ((tag_p == 2'd0) || (din > mx)) ? din : mx;
`ifdef POOL_RELU_EN
    res  = (cand < 0) ? '0 : cand;
`else
    res  = cand;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tag_vld   <= 1'b0;
      tag_p     <= '0;
      mx        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      if (run_n) begin
        tag_vld   <= 1'b0;
        tag_p     <= '0;
        mx        <= '0;
        cnt       <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_idx   <= '0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        busy      <= (state == READ) || (state == DRAIN);
        done      <= (state == DONE);
        tag_vld   <= rd_en;
        tag_p     <= phase;
        out_valid <= 1'b0;
        if (tag_vld) begin
          mx <= cand;
          if (tag_p == 2'd3) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_idx   <= cnt;
            cnt       <= cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_2b2.sv
// Self-checking bench for pool_2b2: buffer model plus a direct max-of-window reference.
module tb_pool_2b2;
  import pool_pkg::*;

  localparam int TIN_W = 6;
  localparam int NWIN  = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_n = 1'b1;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_idx;
  logic        busy;
  logic        done;

  logic [15:0] mem [64];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n0 = 0;
  bit collect = 1'b0;
  int rd_cnt = 0;
  int ov_cnt = 0;
  int          ev_rel[$];
  logic [15:0] ev_data[$];
  logic [3:0]  ev_idx[$];

  pool_2b2 #(.DATA_W(16), .IN_W(6), .IN_H(6), .ADDR_W(6), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .run_n(run_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always @(negedge clk) begin
    if (rd_en) rd_cnt++;
    if (out_valid) begin
      ov_cnt++;
      if (collect) begin
        ev_rel.push_back(cyc - n0);
        ev_data.push_back(out_data);
        ev_idx.push_back(out_idx);
      end
    end
  end

  function automatic logic [15:0] model(int k);
    int base;
    int offs[4];
    data_t m;
    base = 2 * (k / 3) * TIN_W + 2 * (k % 3);
    offs = '{0, 1, TIN_W, TIN_W + 1};
    m = data_t'(mem[base]);
    foreach (offs[i]) if (data_t'(mem[base + offs[i]]) > m) m = data_t'(mem[base + offs[i]]);
`ifdef POOL_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  task automatic start_run();
    @(negedge clk);
    ev_rel.delete(); ev_data.delete(); ev_idx.delete();
    rd_cnt = 0; ov_cnt = 0; collect = 1'b1;
    n0 = cyc + 1;
    run_n = 1'b0;
  endtask

  task automatic wait_done(output int rel);
    rel = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin rel = cyc - n0; break; end
    end
  endtask

  task automatic wait_rel(input int r);
    for (int i = 0; i < 60; i++) begin
      if (cyc - n0 >= r) break;
      @(negedge clk);
    end
  endtask

  task automatic stop_run();
    @(negedge clk);
    run_n = 1'b1;
    @(negedge clk);
    collect = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < 64; a++) mem[a] = 16'(a);
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({rd_en, rd_addr, out_valid, out_data, out_idx, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd_en=%b addr=%0d ov=%b data=%h idx=%0d busy=%b done=%b, want all 0",
               rd_en, rd_addr, out_valid, out_data, out_idx, busy, done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rd_en, busy, done, out_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got rd_en=%b busy=%b done=%b ov=%b, want 0", rd_en, busy, done, out_valid);
    end
  endtask

  task automatic test_ramp();
    int rel;
    int expv[NWIN] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    fill_ramp();
    start_run();
    wait_done(rel);
    n_tests++;
    if (rel !== 39) begin n_fail++; $display("FAIL ramp_done_time: got N+%0d want N+39", rel); end
    n_tests++;
    if (ev_rel.size() !== NWIN) begin n_fail++; $display("FAIL ramp_count: got %0d want %0d", ev_rel.size(), NWIN); end
    for (int k = 0; k < NWIN && k < ev_rel.size(); k++) begin
      n_tests++;
      if (ev_rel[k] !== 6 + 4 * k || ev_data[k] !== 16'(expv[k]) || ev_idx[k] !== 4'(k)) begin
        n_fail++;
        $display("FAIL ramp_win%0d: got t=N+%0d data=%0d idx=%0d want t=N+%0d data=%0d idx=%0d",
                 k, ev_rel[k], ev_data[k], ev_idx[k], 6 + 4 * k, expv[k], k);
      end
    end
    n_tests++;
    if (rd_cnt !== 36) begin n_fail++; $display("FAIL ramp_reads: got %0d want 36", rd_cnt); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_done: got busy=%b want 0", busy); end
    stop_run();
    n_tests++;
    if ({done, rd_en} !== 2'b00) begin n_fail++; $display("FAIL ramp_clear: got done=%b rd_en=%b want 0", done, rd_en); end
  endtask

  task automatic test_negative();
    int rel;
    logic [15:0] e0, er;
    for (int a = 0; a < 64; a++) mem[a] = 16'hFFFB;
    mem[7] = 16'hFFFF;
`ifdef POOL_RELU_EN
    e0 = 16'h0000; er = 16'h0000;
`else
    e0 = 16'hFFFF; er = 16'hFFFB;
`endif
    start_run();
    wait_done(rel);
    n_tests++;
    if (ev_data.size() !== NWIN) begin n_fail++; $display("FAIL neg_count: got %0d want %0d", ev_data.size(), NWIN); end
    for (int k = 0; k < NWIN && k < ev_data.size(); k++) begin
      n_tests++;
      if (ev_data[k] !== ((k == 0) ? e0 : er)) begin
        n_fail++;
        $display("FAIL neg_win%0d: got %h want %h", k, ev_data[k], (k == 0) ? e0 : er);
      end
    end
    stop_run();
  endtask

  task automatic test_signed_random();
    int rel;
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < 64; a++) mem[a] = 16'($urandom);
      if (it == 0) begin
        mem[0] = 16'h8000; mem[1] = 16'h7FFF; mem[6] = 16'h0000; mem[7] = 16'hFFFF;
      end
      start_run();
      wait_done(rel);
      if (it == 0) begin
        n_tests++;
        if (ev_data.size() < 1 || ev_data[0] !== 16'h7FFF) begin
          n_fail++;
          $display("FAIL signed_cmp: got %h want 7fff", (ev_data.size() > 0) ? ev_data[0] : 16'hxxxx);
        end
      end
      n_tests++;
      if (ev_data.size() !== NWIN || rel !== 39) begin
        n_fail++;
        $display("FAIL rand%0d_shape: got count=%0d done=N+%0d want %0d, N+39", it, ev_data.size(), rel, NWIN);
      end
      for (int k = 0; k < NWIN && k < ev_data.size(); k++) begin
        n_tests++;
        if (ev_data[k] !== model(k) || ev_idx[k] !== 4'(k)) begin
          n_fail++;
          $display("FAIL rand%0d_win%0d: got data=%h idx=%0d want data=%h idx=%0d",
                   it, k, ev_data[k], ev_idx[k], model(k), k);
        end
      end
      stop_run();
    end
  endtask

  task automatic test_abort();
    int rel;
    int expv[NWIN] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    fill_ramp();
    start_run();
    wait_rel(10);
    run_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cyc - n0 !== 11 || rd_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: at N+%0d got rd_en=%b done=%b busy=%b want N+11 all 0", cyc - n0, rd_en, done, busy);
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (ev_rel.size() !== 2 || ev_rel[0] !== 6 || ev_rel[1] !== 10 || ov_cnt !== 2) begin
      n_fail++;
      $display("FAIL abort_pulses: got count=%0d want 2 pulses at N+6,N+10", ov_cnt);
    end
    start_run();
    wait_done(rel);
    n_tests++;
    if (rel !== 39 || ev_rel.size() !== NWIN) begin
      n_fail++;
      $display("FAIL restart_shape: got done=N+%0d count=%0d want N+39, %0d", rel, ev_rel.size(), NWIN);
    end
    for (int k = 0; k < NWIN && k < ev_rel.size(); k++) begin
      n_tests++;
      if (ev_rel[k] !== 6 + 4 * k || ev_data[k] !== 16'(expv[k]) || ev_idx[k] !== 4'(k)) begin
        n_fail++;
        $display("FAIL restart_win%0d: got t=N+%0d data=%0d idx=%0d want t=N+%0d data=%0d",
                 k, ev_rel[k], ev_data[k], ev_idx[k], 6 + 4 * k, expv[k]);
      end
    end
    stop_run();
  endtask

  task automatic test_async_reset();
    int rel;
    fill_ramp();
    start_run();
    wait_rel(20);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({rd_en, rd_addr, out_valid, out_data, out_idx, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL async_rst: got rd_en=%b addr=%0d ov=%b data=%h idx=%0d busy=%b, want all 0",
               rd_en, rd_addr, out_valid, out_data, out_idx, busy);
    end
    repeat (3) @(negedge clk);
    ev_rel.delete(); ev_data.delete(); ev_idx.delete();
    n0 = cyc + 1;
    rst = 1'b1;
    wait_done(rel);
    n_tests++;
    if (rel !== 39 || ev_rel.size() !== NWIN) begin
      n_fail++;
      $display("FAIL rst_rerun_shape: got done=N+%0d count=%0d want N+39, %0d", rel, ev_rel.size(), NWIN);
    end
    for (int k = 0; k < NWIN && k < ev_rel.size(); k++) begin
      n_tests++;
      if (ev_rel[k] !== 6 + 4 * k || ev_data[k] !== model(k) || ev_idx[k] !== 4'(k)) begin
        n_fail++;
        $display("FAIL rst_rerun_win%0d: got t=N+%0d data=%0d want t=N+%0d data=%0d",
                 k, ev_rel[k], ev_data[k], 6 + 4 * k, model(k));
      end
    end
    stop_run();
  endtask

  task automatic test_hold_done();
    int rel;
    int nd = 0;
    fill_ramp();
    start_run();
    wait_done(rel);
    @(negedge clk);
    rd_cnt = 0; ov_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (done !== 1'b1) nd++;
    end
    n_tests++;
    if (rel !== 39 || nd !== 0) begin
      n_fail++;
      $display("FAIL hold_done: got done=N+%0d low_cycles=%0d want N+39, 0", rel, nd);
    end
    n_tests++;
    if (rd_cnt !== 0 || ov_cnt !== 0) begin
      n_fail++;
      $display("FAIL hold_quiet: got rd_en=%0d ov=%0d pulses want 0,0", rd_cnt, ov_cnt);
    end
    stop_run();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_signed_random();
    test_abort();
    test_async_reset();
    test_hold_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
